// File: rtl/host_line_responder.sv
// Memory-side responder for the 512-bit host line interface: captures one line
// request, waits LATENCY cycles, then moves the line as 16 word beats against a word RAM.
module host_line_responder #(
  parameter int    LINES     = 64,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op_host,
  input  logic [31:0]  AddrOut_host,
  input  logic [511:0] DataOut_host,
  output logic [511:0] DataIn_host,
  output logic         rd_valid_host,
  output logic         tx_done_host,
  output logic         busy
);

  localparam int         LW       = $clog2(LINES);
  localparam logic [7:0] LAT_LAST = 8'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE, S_REL} state_t;

  state_t              state;
  logic [31:0]         ram [LINES*16];
  logic [LW-1:0]       line_q;
  logic                is_rd;
  logic [15:0][31:0]   wdata_q;
  logic [15:0][31:0]   rd_line;
  logic [3:0]          beat;
  logic [7:0]          lat_cnt;
  logic [LW+3:0]       waddr;

  // Only the line-index bits of the address are decoded; the rest alias.
  logic unused_addr;
  assign unused_addr = ^{AddrOut_host[31:6+LW], AddrOut_host[5:0]};

  assign waddr       = {line_q, beat};
  assign DataIn_host = rd_line;

  // RAM has no reset: a reset mid-write leaves already-written words in place.
  always_ff @(posedge clk) begin
    if (state == S_BEAT && !is_rd) ram[waddr] <= wdata_q[beat];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      beat          <= '0;
      lat_cnt       <= '0;
      line_q        <= '0;
      is_rd         <= 1'b0;
      wdata_q       <= '0;
      rd_line       <= '0;
      rd_valid_host <= 1'b0;
      tx_done_host  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_host == 2'b01 || op_host == 2'b10) begin
            is_rd   <= (op_host == 2'b01);
            line_q  <= AddrOut_host[6 +: LW];
            wdata_q <= DataOut_host;
            beat    <= '0;
            lat_cnt <= '0;
            busy    <= 1'b1;
            state   <= (LATENCY > 0) ? S_WAIT : S_BEAT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) state <= S_BEAT;
          else                     lat_cnt <= lat_cnt + 8'd1;
        end
        S_BEAT: begin
          if (is_rd) rd_line[beat] <= ram[waddr];
          beat <= beat + 4'd1;
          if (beat == 4'd15) begin
            state         <= S_DONE;
            tx_done_host  <= 1'b1;
            rd_valid_host <= is_rd;
          end
        end
        S_DONE: begin
          tx_done_host  <= 1'b0;
          rd_valid_host <= 1'b0;
          state         <= S_REL;
        end
        S_REL: begin
          // Host must drop op before another request is taken.
          if (op_host == 2'b00) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_line_responder.sv
// Bench for host_line_responder: a LATENCY=4 and a LATENCY=0 instance share host
// stimulus and are scored against a per-instance line-array memory model.
module tb_host_line_responder;

  localparam int LINES = 64;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10;

  logic         clk = 1'b0;
  logic         rst4_n, rst0_n;
  logic [1:0]   op_host;
  logic [31:0]  AddrOut_host;
  logic [511:0] DataOut_host;
  logic [511:0] d4_data, d0_data;
  logic         d4_rd, d4_tx, d4_busy, d0_rd, d0_tx, d0_busy;

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m4 [LINES*16];
  logic [31:0] m0 [LINES*16];
  int written[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  host_line_responder #(.LINES(LINES), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .op_host(op_host), .AddrOut_host(AddrOut_host),
    .DataOut_host(DataOut_host), .DataIn_host(d4_data), .rd_valid_host(d4_rd),
    .tx_done_host(d4_tx), .busy(d4_busy));

  host_line_responder #(.LINES(LINES), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .op_host(op_host), .AddrOut_host(AddrOut_host),
    .DataOut_host(DataOut_host), .DataIn_host(d0_data), .rd_valid_host(d0_rd),
    .tx_done_host(d0_tx), .busy(d0_busy));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // One full transaction with op held well past completion, then dropped for one cycle.
  task automatic txn(input logic [1:0] op, input logic [31:0] addr, input logic [511:0] data);
    int ln, cap, t4, t0, nt4, nt0, nr4, nr0;
    logic [511:0] e4, e0;
    ln = int'(addr[11:6]);
    for (int i = 0; i < 16; i++) begin
      e4[32*i +: 32] = m4[ln*16+i];
      e0[32*i +: 32] = m0[ln*16+i];
    end
    if (op == WR) begin
      for (int i = 0; i < 16; i++) begin
        m4[ln*16+i] = data[32*i +: 32];
        m0[ln*16+i] = data[32*i +: 32];
      end
      written.push_back(ln);
    end
    t4 = -1; t0 = -1; nt4 = 0; nt0 = 0; nr4 = 0; nr0 = 0;
    @(negedge clk); op_host = op; AddrOut_host = addr; DataOut_host = data;
    @(posedge clk); #1; cap = cyc;
    chk("busy4_cap", d4_busy, 1); chk("busy0_cap", d0_busy, 1);
    @(negedge clk); AddrOut_host = $urandom; DataOut_host = rand_line();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (d4_tx) begin nt4++; t4 = cyc - cap; if (op == RD) chk("rdata4", d4_data, e4); end
      if (d0_tx) begin nt0++; t0 = cyc - cap; if (op == RD) chk("rdata0", d0_data, e0); end
      if (d4_rd) nr4++;
      if (d0_rd) nr0++;
    end
    chk("ntx4", nt4, 1); chk("ttx4", t4, 20); chk("nrd4", nr4, (op == RD) ? 1 : 0);
    chk("ntx0", nt0, 1); chk("ttx0", t0, 16); chk("nrd0", nr0, (op == RD) ? 1 : 0);
    chk("hold_busy4", d4_busy, 1); chk("hold_busy0", d0_busy, 1);
    @(negedge clk); op_host = 2'b00;
    @(posedge clk); #1;
    chk("rel_busy4", d4_busy, 0); chk("rel_busy0", d0_busy, 0);
  endtask

  // Write line 2 and reset only the LATENCY=4 instance right after its beat-7 edge.
  task automatic rst_mid();
    int cap, t0, nt0;
    logic [511:0] zero;
    zero = '0; t0 = -1; nt0 = 0;
    txn(WR, 32'h80, {16{32'h1111_1111}});
    @(negedge clk); op_host = WR; AddrOut_host = 32'h80; DataOut_host = {16{32'h2222_2222}};
    @(posedge clk); #1; cap = cyc;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 12) begin
        rst4_n = 1'b0; op_host = 2'b00; #1;
        chk("rst_data4", d4_data, zero); chk("rst_busy4", d4_busy, 0);
        chk("rst_tx4", d4_tx, 0);         chk("rst_rd4", d4_rd, 0);
      end
      if (d0_tx) begin nt0++; t0 = cyc - cap; end
    end
    chk("rst_ntx0", nt0, 1); chk("rst_ttx0", t0, 16);
    for (int i = 0; i < 16; i++) begin
      m0[2*16+i] = 32'h2222_2222;
      if (i < 8) m4[2*16+i] = 32'h2222_2222;
    end
    @(negedge clk); rst4_n = 1'b1;
    txn(RD, 32'h80, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [511:0] l, zero;
    logic [31:0] a;
    int ln;
    zero = '0;
    rst4_n = 1'b0; rst0_n = 1'b0; op_host = 2'b00; AddrOut_host = '0; DataOut_host = '0;
    #1;
    chk("reset_data4", d4_data, zero); chk("reset_busy4", d4_busy, 0);
    chk("reset_tx4", d4_tx, 0);         chk("reset_rd4", d4_rd, 0);
    chk("reset_data0", d0_data, zero); chk("reset_busy0", d0_busy, 0);
    @(negedge clk); rst4_n = 1'b1; rst0_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("idle_busy", {d4_busy, d0_busy}, 0);
      chk("idle_tx", {d4_tx, d4_rd, d0_tx, d0_rd}, 0);
    end

    for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'hA5A5_0000 + i;
    txn(WR, 32'h40, l);
    txn(RD, 32'h40, '0);
    txn(RD, 32'h107F, '0);

    @(negedge clk); op_host = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rsv_busy", {d4_busy, d0_busy}, 0);
      chk("rsv_tx", {d4_tx, d0_tx}, 0);
    end
    @(negedge clk); op_host = 2'b00;

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(1) == 0) begin
        ln = $urandom_range(LINES - 1);
        a = ($urandom & 32'hFFFF_F03F) | (32'(ln) << 6);
        txn(WR, a, rand_line());
      end else begin
        ln = written[$urandom_range(written.size() - 1)];
        a = ($urandom & 32'hFFFF_F03F) | (32'(ln) << 6);
        txn(RD, a, rand_line());
      end
    end

    rst_mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
